mvm_stream_feeder: RTL and testbench

Upstream stage of the `mvm_<k>_<p>_<b>_<g>` matrix-vector multiplier. The feeder accepts matrix and vector elements as a valid/ready stream. The multiplier cannot stall, so the feeder buffers each complete frame first, then replays it as an uninterrupted burst on the multiplier's `loadMatrix`/`loadVector`/`data_in` pins. It issues `start` on command and holds off new traffic until the multiplier reports `done`, plus a drain window for the result readout.

---
 rtl/mvm_pkg.sv | 36 +++
 rtl/mvm_stream_feeder_if.sv | 27 ++
 rtl/mvm_stream_feeder_buf.sv | 27 ++
 rtl/mvm_stream_feeder.sv | 199 +++++++++++++++++++
 tb/tb_mvm_stream_feeder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the matrix-vector multiplier front end.
// Module-level sizes are derived from each instance's own K via the helpers.
package mvm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_BURST,
        S_GAP_W,
        S_RUN,
        S_DRAIN_W
    } state_t;

    localparam logic KIND_MAT = 1'b0;
    localparam logic KIND_VEC = 1'b1;

    localparam int K_DEF = 8;

    function automatic int mat_len(input int k);
        return k * k;
    endfunction

    function automatic int vec_len(input int k);
        return k;
    endfunction

    function automatic int cnt_w(input int k);
        return $clog2(k * k + 1);
    endfunction

    localparam int MAT_LEN = mat_len(K_DEF);
    localparam int VEC_LEN = vec_len(K_DEF);
    localparam int CNT_W   = cnt_w(K_DEF);

endpackage

// File: rtl/mvm_stream_feeder_if.sv
// Element stream into the feeder: valid/ready plus frame kind and last flag.
// master drives elements, slave returns ready.
interface mvm_stream_feeder_if #(
    parameter int B = 8
);
    logic                s_valid;
    logic                s_ready;
    logic signed [B-1:0] s_data;
    logic                s_kind;
    logic                s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_kind,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_kind,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/mvm_stream_feeder_buf.sv
// Single-port synchronous frame buffer; a read returns data one cycle later.
// Contents are not reset: every frame is rewritten before it is replayed.
module feeder_buf
    import mvm_pkg::*;
#(
    parameter int DEPTH = MAT_LEN,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mvm_stream_feeder.sv
// Buffers a complete matrix or vector frame, then replays it to the
// multiplier as one unbroken burst; also sequences start/done/drain.
module mvm_stream_feeder
    import mvm_pkg::*;
#(
    parameter int K     = 8,
    parameter int B     = 8,
    parameter int GAP   = 2,
    parameter int DRAIN = K + 2
) (
    input  logic                clk,
    input  logic                reset,
    mvm_stream_feeder_if.slave  s,
    input  logic                cmd_start,
    output logic                cmd_ready,
    output logic                mvm_load_matrix,
    output logic                mvm_load_vector,
    output logic                mvm_start,
    output logic signed [B-1:0] mvm_data_in,
    input  logic                mvm_done,
    output logic                busy,
    output logic                err_len
);

    localparam int CW = cnt_w(K);
    localparam int AW = $clog2(mat_len(K));
    localparam int WW = 16;
    localparam logic [CW-1:0] N_MAT = CW'(mat_len(K));
    localparam logic [CW-1:0] N_VEC = CW'(vec_len(K));

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          kind, kind_n;
    logic          have_a, have_a_n;
    logic          have_x, have_x_n;
    logic          ld_m_n, ld_v_n;
    logic          start_n, err_n;

    logic          buf_en, buf_we, rd_vld;
    logic [AW-1:0] buf_addr;
    logic [B-1:0]  buf_rdata;

    logic          cmd_fire, beat;
    logic          cur_kind, last_ok;
    logic [CW-1:0] exp_len;

    assign cmd_ready = (state == S_IDLE)
                     && have_a && have_x;
    assign cmd_fire  = cmd_ready && cmd_start;

    // A pending command takes priority over a new frame in IDLE.
    assign s.s_ready = (state == S_FILL)
                     || (state == S_IDLE && !cmd_fire);
    assign beat      = s.s_valid && s.s_ready;

    assign busy = !(state == S_IDLE
                 || state == S_FILL);

    assign cur_kind = (state == S_IDLE)
                    ? s.s_kind : kind;
    assign exp_len  = (cur_kind == KIND_VEC)
                    ? N_VEC : N_MAT;
    assign last_ok  = (cnt + CW'(1)) == exp_len;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wcnt_n   = wcnt;
        kind_n   = kind;
        have_a_n = have_a;
        have_x_n = have_x;
        ld_m_n   = 1'b0;
        ld_v_n   = 1'b0;
        start_n  = 1'b0;
        err_n    = 1'b0;
        buf_en   = 1'b0;
        buf_we   = 1'b0;
        buf_addr = cnt[AW-1:0];

        unique case (state)
            S_IDLE, S_FILL: begin
                if (cmd_fire) begin
                    start_n = 1'b1;
                    state_n = S_RUN;
                end else if (beat) begin
                    buf_en = 1'b1;
                    buf_we = 1'b1;
                    if (state == S_IDLE)
                        kind_n = s.s_kind;
                    if (s.s_last && last_ok) begin
                        cnt_n   = '0;
                        state_n = S_ISSUE;
                    end else if (s.s_last || last_ok) begin
                        err_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n   = cnt + CW'(1);
                        state_n = S_FILL;
                    end
                end
            end
            S_ISSUE: begin
                if (kind == KIND_MAT) begin
                    ld_m_n   = 1'b1;
                    have_a_n = 1'b1;
                end else begin
                    ld_v_n   = 1'b1;
                    have_x_n = 1'b1;
                end
                // Address 0 goes out here so data lines up after the load.
                buf_en   = 1'b1;
                buf_addr = '0;
                cnt_n    = CW'(1);
                state_n  = S_BURST;
            end
            S_BURST: begin
                if (cnt == exp_len) begin
                    cnt_n   = '0;
                    wcnt_n  = '0;
                    state_n = (GAP == 0)
                            ? S_IDLE : S_GAP_W;
                end else begin
                    buf_en = 1'b1;
                    cnt_n  = cnt + CW'(1);
                end
            end
            S_GAP_W: begin
                if (wcnt == WW'(GAP - 1)) begin
                    wcnt_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            S_RUN: begin
                if (mvm_done) begin
                    wcnt_n  = '0;
                    state_n = (DRAIN == 0)
                            ? S_IDLE : S_DRAIN_W;
                end
            end
            S_DRAIN_W: begin
                if (wcnt == WW'(DRAIN - 1)) begin
                    wcnt_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            wcnt            <= '0;
            kind            <= KIND_MAT;
            have_a          <= 1'b0;
            have_x          <= 1'b0;
            mvm_load_matrix <= 1'b0;
            mvm_load_vector <= 1'b0;
            mvm_start       <= 1'b0;
            mvm_data_in     <= '0;
            err_len         <= 1'b0;
            rd_vld          <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            wcnt            <= wcnt_n;
            kind            <= kind_n;
            have_a          <= have_a_n;
            have_x          <= have_x_n;
            mvm_load_matrix <= ld_m_n;
            mvm_load_vector <= ld_v_n;
            mvm_start       <= start_n;
            err_len         <= err_n;
            rd_vld          <= buf_en && !buf_we;
            mvm_data_in     <= rd_vld ? buf_rdata : '0;
        end
    end

    feeder_buf #(
        .DEPTH (mat_len(K)),
        .W     (B),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .en    (buf_en),
        .we    (buf_we),
        .addr  (buf_addr),
        .wdata (s.s_data),
        .rdata (buf_rdata)
    );

endmodule

// File: tb/tb_mvm_stream_feeder.sv
// Directed bench for mvm_stream_feeder: a cycle table for the length checks
// plus hand-written sequences for bursts, commands, arbitration and reset.
module tb_mvm_stream_feeder;

    localparam int K     = 8;
    localparam int B     = 8;
    localparam int GAP   = 2;
    localparam int DRAIN = K + 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_start = 1'b0;
    logic                mvm_done = 1'b0;
    logic                cmd_ready;
    logic                mvm_load_matrix;
    logic                mvm_load_vector;
    logic                mvm_start;
    logic signed [B-1:0] mvm_data_in;
    logic                busy;
    logic                err_len;

    mvm_stream_feeder_if #(.B(B)) sif();

    mvm_stream_feeder #(
        .K(K), .B(B), .GAP(GAP), .DRAIN(DRAIN)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s               (sif),
        .cmd_start       (cmd_start),
        .cmd_ready       (cmd_ready),
        .mvm_load_matrix (mvm_load_matrix),
        .mvm_load_vector (mvm_load_vector),
        .mvm_start       (mvm_start),
        .mvm_data_in     (mvm_data_in),
        .mvm_done        (mvm_done),
        .busy            (busy),
        .err_len         (err_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       o_sr, o_cr, o_lm, o_lv, o_st;
    logic       o_busy, o_err;
    logic [7:0] o_dout;
    logic [7:0] fd [64];

    // flags order: {s_ready, cmd_ready, load_m, load_v, start, busy, err}
    typedef struct {
        string      nm;
        logic       v, k, l, cs, dn;
        logic [7:0] d;
        logic [6:0] e_flags;
        logic [7:0] e_dout;
    } row_t;

    row_t tbl[$];

    localparam logic [6:0] F_IDLE = 7'b1000000;
    localparam logic [6:0] F_ERR  = 7'b1000001;

    function automatic row_t mk(
        input string nm, input logic v, input logic k,
        input logic l, input logic cs, input logic dn,
        input logic [7:0] d, input logic [6:0] ef,
        input logic [7:0] ed);
        row_t r;
        r.nm = nm; r.v = v; r.k = k; r.l = l;
        r.cs = cs; r.dn = dn; r.d = d;
        r.e_flags = ef; r.e_dout = ed;
        return r;
    endfunction

    task automatic cyc();
        @(negedge clk);
        o_sr   = sif.s_ready;
        o_cr   = cmd_ready;
        o_lm   = mvm_load_matrix;
        o_lv   = mvm_load_vector;
        o_st   = mvm_start;
        o_busy = busy;
        o_err  = err_len;
        o_dout = mvm_data_in;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic kind, input int n,
                              input int last_at, input bit gaps);
        for (int b = 1; b <= n; b++) begin
            sif.s_valid = 1'b1;
            // kind is flipped after beat 1 to show it is only sampled once
            sif.s_kind  = (b == 1) ? kind : ~kind;
            sif.s_last  = (b == last_at);
            sif.s_data  = fd[b-1];
            cyc();
            chk($sformatf("beat_ready_%0d", b), 32'(o_sr), 32'd1);
            if (gaps && b < n) begin
                sif.s_valid = 1'b0;
                cyc();
            end
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic expect_burst(input logic kind, input int n);
        cyc();
        chk("load_lat", 32'({o_lm, o_lv}), 32'd0);
        cyc();
        chk("load_pulse", 32'({o_lm, o_lv}),
            kind ? 32'b01 : 32'b10);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk($sformatf("burst_%0d", i),
                32'({o_sr, o_lm, o_lv, o_busy, o_err, o_dout}),
                32'({5'b00010, fd[i]}));
        end
        cyc();
        chk("burst_end", 32'({o_busy, o_dout}), 32'({1'b1, 8'h00}));
        cyc();
        chk("gap_done", 32'({o_busy, o_sr, o_err}), 32'b010);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.s_valid = 1'b0;
        sif.s_kind  = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_data  = '0;

        tbl.push_back(mk("rst", 0,0,0,0,0, 0, F_IDLE, 0));
        tbl.push_back(mk("done_idle", 0,0,0,0,1, 0, F_IDLE, 0));
        tbl.push_back(mk("cmd_noflag", 0,0,0,1,0, 0, F_IDLE, 0));
        tbl.push_back(mk("no_start", 0,0,0,0,0, 0, F_IDLE, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk("short_beat", 1, (i == 1), (i == 5),
                             0, 0, 8'(i), F_IDLE, 0));
        tbl.push_back(mk("short_err", 0,0,0,0,0, 0, F_ERR, 0));
        tbl.push_back(mk("short_clr", 0,0,0,0,0, 0, F_IDLE, 0));
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk("long_beat", 1,1,0,0,0, 8'(i),
                             F_IDLE, 0));
        tbl.push_back(mk("long_err", 0,0,0,0,0, 0, F_ERR, 0));
        tbl.push_back(mk("long_clr", 0,0,0,0,0, 0, F_IDLE, 0));
        tbl.push_back(mk("no_load", 0,0,0,0,0, 0, F_IDLE, 0));
        tbl.push_back(mk("cmd_still_off", 0,0,0,1,0, 0, F_IDLE, 0));

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[r]) begin
            sif.s_valid = tbl[r].v;
            sif.s_kind  = tbl[r].k;
            sif.s_last  = tbl[r].l;
            sif.s_data  = tbl[r].d;
            cmd_start   = tbl[r].cs;
            mvm_done    = tbl[r].dn;
            cyc();
            chk(tbl[r].nm,
                32'({o_sr, o_cr, o_lm, o_lv, o_st,
                     o_busy, o_err, o_dout}),
                32'({tbl[r].e_flags, tbl[r].e_dout}));
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        cmd_start   = 1'b0;
        mvm_done    = 1'b0;

        for (int i = 0; i < 64; i++) fd[i] = 8'(i + 1);
        send_frame(1'b0, 64, 64, 1'b0);
        expect_burst(1'b0, 64);
        chk("cr_a_only", 32'(o_cr), 32'd0);

        for (int i = 0; i < 8; i++) fd[i] = 8'(-(i + 1));
        send_frame(1'b1, 8, 8, 1'b1);
        expect_burst(1'b1, 8);
        chk("cr_both", 32'(o_cr), 32'd1);

        cmd_start = 1'b1;
        cyc();
        chk("cmd_hs", 32'({o_sr, o_cr, o_st}), 32'b010);
        cmd_start = 1'b0;
        cyc();
        chk("start_pulse", 32'({o_sr, o_cr, o_st, o_busy}), 32'b0011);
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("run_wait", 32'({o_sr, o_st, o_busy}), 32'b001);
        end
        mvm_done = 1'b1;
        cyc();
        chk("done_run", 32'({o_sr, o_busy}), 32'b01);
        mvm_done = 1'b0;
        for (int j = 0; j < DRAIN; j++) begin
            cyc();
            chk($sformatf("drain_%0d", j),
                32'({o_sr, o_busy}), 32'b01);
        end
        cyc();
        chk("drain_end", 32'({o_sr, o_cr, o_busy}), 32'b110);

        for (int i = 0; i < 8; i++) fd[i] = 8'(8'h55 + i);
        sif.s_valid = 1'b1;
        sif.s_kind  = 1'b1;
        sif.s_last  = 1'b0;
        sif.s_data  = fd[0];
        cmd_start   = 1'b1;
        cyc();
        chk("arb_cmd", 32'({o_sr, o_cr}), 32'b01);
        cmd_start = 1'b0;
        cyc();
        chk("arb_start", 32'({o_sr, o_st}), 32'b01);
        mvm_done = 1'b1;
        cyc();
        chk("arb_done", 32'(o_sr), 32'd0);
        mvm_done = 1'b0;
        for (int j = 0; j < DRAIN; j++) begin
            cyc();
            chk("arb_hold", 32'(o_sr), 32'd0);
        end
        send_frame(1'b1, 8, 8, 1'b0);
        expect_burst(1'b1, 8);

        for (int i = 0; i < 64; i++) fd[i] = 8'(i + 100);
        send_frame(1'b0, 64, 64, 1'b0);
        cyc();
        cyc();
        chk("rl_load", 32'(o_lm), 32'd1);
        for (int i = 0; i < 29; i++) begin
            cyc();
            chk($sformatf("rl_burst_%0d", i), 32'(o_dout), 32'(fd[i]));
        end
        reset = 1'b1;
        cyc();
        chk("rl_el30", 32'(o_dout), 32'(fd[29]));
        reset = 1'b0;
        cyc();
        chk("rst_mid",
            32'({o_sr, o_cr, o_lm, o_lv, o_st, o_busy, o_err, o_dout}),
            32'({F_IDLE, 8'h00}));
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("rst_quiet", 32'({o_busy, o_lm, o_lv, o_cr, o_dout}),
                32'd0);
        end

        for (int i = 0; i < 8; i++) fd[i] = 8'(i * 3);
        send_frame(1'b1, 8, 8, 1'b0);
        expect_burst(1'b1, 8);
        chk("cr_x_only", 32'(o_cr), 32'd0);

        for (int i = 0; i < 64; i++) fd[i] = 8'(200 - i);
        send_frame(1'b0, 64, 64, 1'b0);
        expect_burst(1'b0, 64);
        chk("cr_reload", 32'(o_cr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
